// File: rtl/alu_op_sequencer_if.sv
// Control/datapath bundle for the ALU op sequencer.
// master is the sequencer side; slave is the control unit / datapath side.
interface alu_op_sequencer_if #(
    parameter int OPC_W = 5
);
    logic             start;
    logic [OPC_W-1:0] opcode;
    logic [3:0]       op;
    logic             RAout;
    logic             RBout;
    logic             Yin;
    logic             Zin;
    logic             ZLowout;
    logic             ZHighout;
    logic             Rin;
    logic             LOin;
    logic             HIin;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, opcode,
        output op, RAout, RBout, Yin, Zin, ZLowout, ZHighout,
        output Rin, LOin, HIin, busy, done, err
    );

    modport slave (
        output start, opcode,
        input  op, RAout, RBout, Yin, Zin, ZLowout, ZHighout,
        input  Rin, LOin, HIin, busy, done, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: decodes the IR opcode and steps Y-load, ALU eval/Z-capture
// and Z-drain through a Moore FSM with registered strobes.
module alu_op_sequencer #(
    parameter int ALU_LATENCY = 1,
    parameter int OPC_W       = 5
) (
    input  logic                clock,
    input  logic                clear,
    alu_op_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, LOADY, EVAL, WRLO, WRHI, DONE
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       unary;
        logic       wide;
        logic [3:0] op;
    } dec_t;

    typedef struct packed {
        logic ra, rb, yin, zin, zlo, zhi;
        logic rin, lo, hi, busy, done, err;
    } ctl_t;

    localparam logic [3:0] LAST = 4'(ALU_LATENCY - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] op_q, op_n;
    logic       unary_q, unary_n;
    logic       wide_q, wide_n;
    logic       ill_q, ill_n;
    ctl_t       ctl_q, ctl_n;
    dec_t       dec;

    function automatic dec_t decode(input logic [OPC_W-1:0] opc);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        unique case (1'b1)
            (opc == OPC_W'(3)):  d.op = 4'h4;
            (opc == OPC_W'(4)):  d.op = 4'h5;
            (opc == OPC_W'(5)):  d.op = 4'h0;
            (opc == OPC_W'(6)):  d.op = 4'h1;
            (opc == OPC_W'(7)):  d.op = 4'hB;
            (opc == OPC_W'(8)):  d.op = 4'hC;
            (opc == OPC_W'(9)):  d.op = 4'h8;
            (opc == OPC_W'(10)): d.op = 4'h9;
            (opc == OPC_W'(11)): d.op = 4'hA;
            (opc == OPC_W'(15)): begin d.op = 4'h6; d.wide = 1'b1; end
            (opc == OPC_W'(16)): begin d.op = 4'h7; d.wide = 1'b1; end
            (opc == OPC_W'(17)): begin d.op = 4'h2; d.unary = 1'b1; end
            (opc == OPC_W'(18)): begin d.op = 4'h3; d.unary = 1'b1; end
            default:             d.legal = 1'b0;
        endcase
        return d;
    endfunction

    assign dec = decode(bus.opcode);

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        op_n    = op_q;
        unary_n = unary_q;
        wide_n  = wide_q;
        ill_n   = ill_q;
        ctl_n   = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    unary_n = dec.unary;
                    wide_n  = dec.wide;
                    ill_n   = ~dec.legal;
                    if (dec.legal) begin
                        op_n    = dec.op;
                        state_n = LOADY;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            LOADY: state_n = EVAL;
            EVAL: begin
                if (cnt == LAST) state_n = WRLO;
                else             cnt_n   = cnt + 4'd1;
            end
            WRLO: state_n = wide_n ? WRHI : DONE;
            WRHI: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Strobes are decoded from the next state so they register in step with it.
        ctl_n.ra   = (state_n == LOADY);
        ctl_n.yin  = (state_n == LOADY);
        ctl_n.rb   = (state_n == EVAL) && !unary_n;
        ctl_n.zin  = (state_n == EVAL) && (cnt_n == LAST);
        ctl_n.zlo  = (state_n == WRLO);
        ctl_n.rin  = (state_n == WRLO) && !wide_n;
        ctl_n.lo   = (state_n == WRLO) && wide_n;
        ctl_n.zhi  = (state_n == WRHI);
        ctl_n.hi   = (state_n == WRHI);
        ctl_n.busy = (state_n != IDLE);
        ctl_n.done = (state_n == DONE);
        ctl_n.err  = (state_n == DONE) && ill_n;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            unary_q <= 1'b0;
            wide_q  <= 1'b0;
            ill_q   <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            op_q    <= op_n;
            unary_q <= unary_n;
            wide_q  <= wide_n;
            ill_q   <= ill_n;
            ctl_q   <= ctl_n;
        end
    end

    assign bus.op       = op_q;
    assign bus.RAout    = ctl_q.ra;
    assign bus.RBout    = ctl_q.rb;
    assign bus.Yin      = ctl_q.yin;
    assign bus.Zin      = ctl_q.zin;
    assign bus.ZLowout  = ctl_q.zlo;
    assign bus.ZHighout = ctl_q.zhi;
    assign bus.Rin      = ctl_q.rin;
    assign bus.LOin     = ctl_q.lo;
    assign bus.HIin     = ctl_q.hi;
    assign bus.busy     = ctl_q.busy;
    assign bus.done     = ctl_q.done;
    assign bus.err      = ctl_q.err;
endmodule
